uvma_axi_wr_responder: RTL and testbench
========================================

// Module: uvma_axi_wr_responder
// PURPOSE
//  Synthesisable AXI write-path slave responder on the slave side of the AXI agent's interface signals.
//  - Consumes AW and W; emits one memory write strobe per accepted beat; returns B.
//  - Queues up to AW_DEPTH outstanding write addresses.
//  - Services them strictly in order, one burst at a time.
// PARAMETERS
//  ID_WIDTH    4   AXI ID width (aw_id, b_id)
//  ADDR_WIDTH  64  address width
//  DATA_WIDTH  64  data width; strobe width = DATA_WIDTH/8
//  AW_DEPTH    4   AW queue entries; power of two, >=2
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  rst        in   1              synchronous active-high reset
//  aw_id      in   ID_WIDTH       write ID
//  aw_addr    in   ADDR_WIDTH     burst start address
//  aw_len     in   8              beats-1
//  aw_size    in   3              log2 bytes/beat, <= log2(DATA_WIDTH/8)
//  aw_burst   in   2              00 FIXED, 01 INCR, 10 WRAP
//  aw_lock    in   1              exclusive access
//  aw_valid   in   1              AW valid
//  aw_ready   out  1              AW ready
//  w_data     in   DATA_WIDTH     write data
//  w_strb     in   DATA_WIDTH/8   byte strobes
//  w_last     in   1              last beat marker
//  w_valid    in   1              W valid
//  w_ready    out  1              W ready
//  b_id       out  ID_WIDTH       response ID (= aw_id of burst)
//  b_resp     out  2              00 OKAY, 01 EXOKAY, 10 SLVERR
//  b_valid    out  1              B valid
//  b_ready    in   1              B ready
//  mem_we     out  1              one-cycle write strobe per accepted W beat
//  mem_addr   out  ADDR_WIDTH     beat address
//  mem_wdata  out  DATA_WIDTH     registered w_data
//  mem_wstrb  out  DATA_WIDTH/8   registered w_strb
// BEHAVIOUR
//  Reset (rst=1 at clk edge)
//  - Clears queue, state=IDLE, beat counter 0.
//  - Reset values: aw_ready=0, w_ready=0, b_valid=0, b_id=0, b_resp=0, mem_we=0, mem_addr/wdata/wstrb=0.
//  - Mid-burst reset abandons the burst; no B is issued.
//  - From the first cycle after reset, aw_ready=1.
//  AW queue
//  - Push on aw_valid&aw_ready; aw_ready = !full (registered count).
//  - Pop only on B handshake; no bypass.
//  - Push and pop in the same cycle keep the count unchanged.
//  - When full, aw_ready stays 0 even if a pop occurs that cycle.
//  FSM: IDLE -> DATA -> RESP -> IDLE
//  - IDLE: if queue non-empty, load the head into addr/cnt registers (cnt=0, err=0); next DATA.
//  - DATA: w_ready=1. Each w_valid&w_ready beat:
//    - mem_we=1 next cycle, with mem_addr = current beat address.
//    - Then cnt++ and advance the address.
//    - On the beat where cnt==aw_len, go to RESP. Beat count is authoritative; termination does not depend on w_last.
//  - RESP: b_valid=1, with b_id/b_resp stable until b_ready.
//    - On handshake: b_valid=0, pop the queue, go to IDLE.
//    - A queued next burst enters DATA one cycle after IDLE.
//  - Latency: b_valid rises the cycle after the final W handshake; w_ready=0 in IDLE and RESP.
//  Address arithmetic (bytes = 1<<aw_size)
//  - FIXED: address unchanged.
//  - INCR: addr += bytes, ADDR_WIDTH modulo.
//  - WRAP: boundary = (aw_len+1)*bytes; addr = base | ((addr+bytes) & (boundary-1)), where base = start & ~(boundary-1).
//  - WRAP with aw_len not in {1,3,7,15}, or aw_burst=11: behave as INCR and set err.
//  b_resp: err ? SLVERR : (aw_lock ? EXOKAY : OKAY).
// CONFIGURATION
//  Macro UVMA_AXI_WR_LAST_CHK_EN, defined:
//  - err also set on any beat where w_last != (cnt==aw_len).
//  - Adds output err_cnt (16 bits): increments once per erroneous burst at B handshake, saturates at 16'hFFFF, reset 0.
//  Undefined: w_last ignored; no err_cnt port.
// TESTING
//  INCR id=3 addr=0x100 len=3 size=3, 4 beats, b_ready=1 -> mem_addr 0x100,0x108,0x110,0x118; B id=3 OKAY 1 cycle after beat 4.
//  WRAP addr=0x118 len=3 size=3 -> mem_addr 0x118,0x100,0x108,0x110; b_resp=OKAY.
//  Five AWs pushed back-to-back with AW_DEPTH=4, b_ready=0 -> aw_ready=0 after the 4th; the 5th is accepted after the first B handshake.
//  FIXED aw_lock=1 len=1 addr=0x40 -> two writes at 0x40; b_resp=EXOKAY; b_valid held 3 cycles while b_ready=0.
//  LAST_CHK_EN: len=3 with w_last on beat 2 -> burst still takes 4 beats; b_resp=SLVERR; err_cnt=1.
//  rst=1 during beat 2 of len=7 -> next cycle all outputs at reset values; no B; a new AW completes normally.

Source files
------------

// File: rtl/uvma_axi_wr_responder.sv
`default_nettype none
// ============================================================================
// Module      : uvma_axi_wr_responder
// Description : AXI write-path slave responder. Queues AW requests, accepts W
//               beats in order, issues one mem write strobe per beat, returns B.
//               Optional macro UVMA_AXI_WR_LAST_CHK_EN adds w_last checking
//               and the err_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module uvma_axi_wr_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int AW_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     aw_id,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]              aw_len,
    input  logic [2:0]              aw_size,
    input  logic [1:0]              aw_burst,
    input  logic                    aw_lock,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_last,
    input  logic                    w_valid,
    output logic                    w_ready,
    output logic [ID_WIDTH-1:0]     b_id,
    output logic [1:0]              b_resp,
    output logic                    b_valid,
    input  logic                    b_ready,
`ifdef UVMA_AXI_WR_LAST_CHK_EN
    output logic [15:0]             err_cnt,
`endif
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_PTR_W  = $clog2(AW_DEPTH);
    localparam int c_AW_W   = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1;
    localparam logic [c_PTR_W:0]     c_FULL = (c_PTR_W + 1)'(AW_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DATA = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;
    localparam logic [1:0] c_BURST_RSVD  = 2'b11;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic [c_AW_W-1:0]     r_q [AW_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic [c_PTR_W:0]      w_count_nxt;
    logic                  r_aw_ready;

    logic [1:0]            r_state;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_err;
    logic                  r_b_valid;
    logic [ID_WIDTH-1:0]   r_b_id;
    logic [1:0]            r_b_resp;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [c_STRB_W-1:0]   r_mem_wstrb;

    logic [ID_WIDTH-1:0]   w_hd_id;
    logic [ADDR_WIDTH-1:0] w_hd_addr;
    logic [7:0]            w_hd_len;
    logic [2:0]            w_hd_size;
    logic [1:0]            w_hd_burst;
    logic                  w_hd_lock;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_wrap_ok;
    logic                  w_bad_burst;
    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_final_beat;
    logic                  w_last_err;
    logic                  w_err_beat;

    assign {w_hd_id, w_hd_addr, w_hd_len, w_hd_size, w_hd_burst, w_hd_lock} = r_q[r_rd_ptr];

    assign w_push = aw_valid & r_aw_ready;
    assign w_pop  = r_b_valid & b_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Only power-of-two wrap lengths of 2/4/8/16 beats are legal; others fall back to INCR
    assign w_wrap_ok   = (w_hd_burst == c_BURST_WRAP) &&
                         ((w_hd_len == 8'd1) || (w_hd_len == 8'd3) ||
                          (w_hd_len == 8'd7) || (w_hd_len == 8'd15));
    assign w_bad_burst = (w_hd_burst == c_BURST_RSVD) ||
                         ((w_hd_burst == c_BURST_WRAP) && !w_wrap_ok);

    assign w_bytes     = c_ONE << w_hd_size;
    assign w_wrap_mask = ((({{(ADDR_WIDTH-8){1'b0}}, w_hd_len}) + c_ONE) << w_hd_size) - c_ONE;
    assign w_incr      = r_addr + w_bytes;

    always_comb begin
        w_addr_nxt = w_incr;
        if (w_hd_burst == c_BURST_FIXED) begin
            w_addr_nxt = r_addr;
        end else if (w_wrap_ok) begin
            w_addr_nxt = (r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
        end
    end

    assign w_final_beat = (r_cnt == w_hd_len);

`ifdef UVMA_AXI_WR_LAST_CHK_EN
    logic [15:0] r_err_cnt;
    assign w_last_err = (w_last != w_final_beat);
    assign err_cnt    = r_err_cnt;
`else
    logic w_unused_last;
    assign w_unused_last = w_last;
    assign w_last_err    = 1'b0;
`endif

    assign w_err_beat = r_err | w_last_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wr_ptr] <= {aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_aw_ready  <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_cnt       <= 8'd0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_b_valid   <= 1'b0;
            r_b_id      <= '0;
            r_b_resp    <= c_RESP_OKAY;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
`ifdef UVMA_AXI_WR_LAST_CHK_EN
            r_err_cnt   <= 16'd0;
`endif
        end else begin
            // Ready derives from the updated count, so a pop while full cannot reopen it in the same cycle
            r_count    <= w_count_nxt;
            r_aw_ready <= (w_count_nxt != c_FULL);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_mem_we <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (r_count != '0) begin
                        r_addr  <= w_hd_addr;
                        r_cnt   <= 8'd0;
                        r_err   <= w_bad_burst;
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_data;
                        r_mem_wstrb <= w_strb;
                        r_cnt       <= r_cnt + 8'd1;
                        r_addr      <= w_addr_nxt;
                        r_err       <= w_err_beat;
                        if (w_final_beat) begin
                            r_state   <= c_ST_RESP;
                            r_b_valid <= 1'b1;
                            r_b_id    <= w_hd_id;
                            r_b_resp  <= w_err_beat ? c_RESP_SLVERR :
                                         (w_hd_lock ? c_RESP_EXOKAY : c_RESP_OKAY);
                        end
                    end
                end
                c_ST_RESP: begin
                    if (b_ready) begin
                        r_b_valid <= 1'b0;
                        r_state   <= c_ST_IDLE;
`ifdef UVMA_AXI_WR_LAST_CHK_EN
                        if (r_err && (r_err_cnt != 16'hFFFF)) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
`endif
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign aw_ready  = r_aw_ready;
    assign w_ready   = (r_state == c_ST_DATA);
    assign b_valid   = r_b_valid;
    assign b_id      = r_b_id;
    assign b_resp    = r_b_resp;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_uvma_axi_wr_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uvma_axi_wr_responder
// Description : Directed self-checking bench for uvma_axi_wr_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uvma_axi_wr_responder;

    logic        clk;
    logic        rst;
    logic [3:0]  aw_id;
    logic [63:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_lock;
    logic        aw_valid;
    logic        aw_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
`ifdef UVMA_AXI_WR_LAST_CHK_EN
    logic [15:0] err_cnt;
`endif

    uvma_axi_wr_responder #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .AW_DEPTH   (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .aw_id     (aw_id),
        .aw_addr   (aw_addr),
        .aw_len    (aw_len),
        .aw_size   (aw_size),
        .aw_burst  (aw_burst),
        .aw_lock   (aw_lock),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_last    (w_last),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .b_id      (b_id),
        .b_resp    (b_resp),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
`ifdef UVMA_AXI_WR_LAST_CHK_EN
        .err_cnt   (err_cnt),
`endif
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    localparam logic [63:0] c_DATA_BASE = 64'hDA7A_0000_0000_0000;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc   = 0;
    int          last_w_cyc;
    int          b_rise_cyc;
    logic        r_prev_bv;
    logic [63:0] wq_addr [$];
    logic [63:0] wq_data [$];
    logic [7:0]  wq_strb [$];
    logic [3:0]  bq_id   [$];
    logic [1:0]  bq_resp [$];
    logic [63:0] exp_a   [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe DUT outputs only, on the falling edge
    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_strb.push_back(mem_wstrb);
        end
        if (b_valid && !r_prev_bv) begin
            bq_id.push_back(b_id);
            bq_resp.push_back(b_resp);
            b_rise_cyc = cyc;
        end
        r_prev_bv = b_valid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_logs();
        wq_addr.delete();
        wq_data.delete();
        wq_strb.delete();
        bq_id.delete();
        bq_resp.delete();
        exp_a.delete();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, 64'(wq_addr.size()), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            chk({tag, "_addr"}, (i < wq_addr.size()) ? wq_addr[i] : 64'hx, exp_a[i]);
        end
    endtask

    // All driving tasks start and end on a falling edge
    task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic lock);
        int k = 0;
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size;
        aw_burst = burst; aw_lock = lock; aw_valid = 1'b1;
        while (!aw_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("aw_handshake", 64'(aw_ready), 64'd1);
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    task automatic send_w(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            w_data  = c_DATA_BASE | 64'(i);
            w_strb  = (i == 0) ? 8'h0F : 8'hFF;
            w_last  = (i == last_idx);
            w_valid = 1'b1;
            while (!w_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("w_handshake", 64'(w_ready), 64'd1);
            last_w_cyc = cyc;
            @(negedge clk);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic wait_bcount(input int n);
        int k = 0;
        while (bq_id.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("b_count", 64'(bq_id.size()), 64'(n));
    endtask

    task automatic wait_bvalid();
        int k = 0;
        while (!b_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("b_valid_seen", 64'(b_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_aw_ready"},  64'(aw_ready), 64'd0);
        chk({tag, "_w_ready"},   64'(w_ready), 64'd0);
        chk({tag, "_b_valid"},   64'(b_valid), 64'd0);
        chk({tag, "_b_id"},      64'(b_id), 64'd0);
        chk({tag, "_b_resp"},    64'(b_resp), 64'd0);
        chk({tag, "_mem_we"},    64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"},  mem_addr, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
`ifdef UVMA_AXI_WR_LAST_CHK_EN
        chk({tag, "_err_cnt"},   64'(err_cnt), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0;
        aw_burst = '0; aw_lock = 1'b0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
        r_prev_bv = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("aw_ready_after_reset", 64'(aw_ready), 64'd1);

        // INCR burst, latency of B after last beat
        clr_logs();
        send_aw(4'd3, 64'h100, 8'd3, 3'd3, 2'b01, 1'b0);
        send_w(4, 3);
        wait_bcount(1);
        exp_a = '{64'h100, 64'h108, 64'h110, 64'h118};
        check_writes("incr");
        chk("incr_wdata0", wq_data[0], c_DATA_BASE);
        chk("incr_wstrb0", 64'(wq_strb[0]), 64'h0F);
        chk("incr_wdata3", wq_data[3], c_DATA_BASE | 64'd3);
        chk("incr_b_id", 64'(bq_id[0]), 64'd3);
        chk("incr_b_resp", 64'(bq_resp[0]), 64'd0);
        chk("incr_b_latency", 64'(b_rise_cyc), 64'(last_w_cyc + 1));

        // WRAP across a 32-byte window
        clr_logs();
        send_aw(4'd4, 64'h118, 8'd3, 3'd3, 2'b10, 1'b0);
        send_w(4, 3);
        wait_bcount(1);
        exp_a = '{64'h118, 64'h100, 64'h108, 64'h110};
        check_writes("wrap");
        chk("wrap_b_resp", 64'(bq_resp[0]), 64'd0);

        // WRAP with illegal length behaves as INCR with SLVERR; reserved burst type too
        clr_logs();
        send_aw(4'd5, 64'h300, 8'd2, 3'd2, 2'b10, 1'b0);
        send_w(3, 2);
        wait_bcount(1);
        send_aw(4'd6, 64'h380, 8'd1, 3'd1, 2'b11, 1'b1);
        send_w(2, 1);
        wait_bcount(2);
        exp_a = '{64'h300, 64'h304, 64'h308, 64'h380, 64'h382};
        check_writes("badburst");
        chk("badwrap_b_resp", 64'(bq_resp[0]), 64'd2);
        chk("rsvd_b_resp", 64'(bq_resp[1]), 64'd2);

        // Queue fills at four entries; fifth accepted only after the first B handshake
        clr_logs();
        b_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_aw(4'(i), 64'h200 + 64'(16 * (i - 1)), 8'd0, 3'd3, 2'b01, 1'b0);
        end
        chk("q_full_aw_ready", 64'(aw_ready), 64'd0);
        aw_id = 4'd5; aw_addr = 64'h240; aw_len = 8'd0; aw_size = 3'd3;
        aw_burst = 2'b01; aw_lock = 1'b0; aw_valid = 1'b1;
        send_w(1, 0);
        wait_bvalid();
        chk("q_first_b_id", 64'(b_id), 64'd1);
        @(negedge clk);
        chk("q_full_hold", 64'(aw_ready), 64'd0);
        b_ready = 1'b1;
        @(negedge clk);
        chk("q_pop_frees", 64'(aw_ready), 64'd1);
        chk("q_pop_b_valid", 64'(b_valid), 64'd0);
        @(negedge clk);
        aw_valid = 1'b0;
        chk("q_refill", 64'(aw_ready), 64'd0);
        for (int i = 0; i < 4; i++) send_w(1, 0);
        wait_bcount(5);
        for (int i = 0; i < 5; i++) begin
            chk("q_b_order", (i < bq_id.size()) ? 64'(bq_id[i]) : 64'hx, 64'(i + 1));
        end
        exp_a = '{64'h200, 64'h210, 64'h220, 64'h230, 64'h240};
        check_writes("queue");

        // FIXED exclusive burst with B held under back-pressure
        clr_logs();
        b_ready = 1'b0;
        send_aw(4'd7, 64'h40, 8'd1, 3'd3, 2'b00, 1'b1);
        send_w(2, 1);
        wait_bvalid();
        chk("fixed_b_resp", 64'(b_resp), 64'd1);
        chk("fixed_b_id", 64'(b_id), 64'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fixed_b_hold", 64'(b_valid), 64'd1);
            chk("fixed_resp_hold", 64'(b_resp), 64'd1);
        end
        b_ready = 1'b1;
        @(negedge clk);
        chk("fixed_b_drop", 64'(b_valid), 64'd0);
        exp_a = '{64'h40, 64'h40};
        check_writes("fixed");

        // Reset during beat 2 of an 8-beat burst
        clr_logs();
        send_aw(4'd8, 64'h500, 8'd7, 3'd3, 2'b01, 1'b0);
        send_w(1, 7);
        w_data = c_DATA_BASE | 64'd1; w_strb = 8'hFF; w_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        w_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_no_b", 64'(bq_id.size()), 64'd0);
        chk("midrst_writes", 64'(wq_addr.size()), 64'd1);
        clr_logs();
        send_aw(4'd9, 64'h700, 8'd1, 3'd3, 2'b01, 1'b0);
        send_w(2, 1);
        wait_bcount(1);
        chk("midrst_new_b_id", 64'(bq_id[0]), 64'd9);
        chk("midrst_new_b_resp", 64'(bq_resp[0]), 64'd0);
        exp_a = '{64'h700, 64'h708};
        check_writes("midrst_new");

`ifdef UVMA_AXI_WR_LAST_CHK_EN
        // Early w_last: beat count still governs, burst flagged
        clr_logs();
        send_aw(4'd10, 64'h600, 8'd3, 3'd3, 2'b01, 1'b0);
        send_w(4, 1);
        wait_bcount(1);
        @(negedge clk);
        exp_a = '{64'h600, 64'h608, 64'h610, 64'h618};
        check_writes("lastchk");
        chk("lastchk_b_resp", 64'(bq_resp[0]), 64'd2);
        chk("lastchk_err_cnt", 64'(err_cnt), 64'd1);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
